aes_key_schedule_multi: RTL
===========================

// Module: aes_key_schedule_multi
// PURPOSE
//  Iterative AES key expander for AES-128/192/256, selectable at run time per start.
//  Produces one 32-bit schedule word per clock into an internal round-key store.
//  Once expansion is complete, serves any round key by index to the round datapath.
//  Feeds the encryption core; successor to the fixed 128-bit key expander.
// PARAMETERS
//  MAX_KEY_WIDTH  256  largest supported key (128|192|256); sets store depth MAX_NW=4*(MAX_NK+7)
//  MAX_NK         MAX_KEY_WIDTH/32  derived, not overridable
// PORTS
//  clk         in   1             single clock, rising edge
//  resetn      in   1             asynchronous, active-low reset
//  encrypt_en  in   1             level request: start expansion / hold result
//  key_mode    in   2             0=AES-128 1=AES-192 2=AES-256 3=reserved; sampled at start
//  cipher_key  in   [7:0][3:0][MAX_NK-1:0]  key bytes, [row][col], col c = key word c, row r = byte r of word
//  key_sel     in   4             round-key index 0..Nr
//  busy        out  1             expansion in progress
//  key_rdy     out  1             schedule complete and valid
//  key_err     out  1             one-cycle pulse: illegal mode rejected
//  round_key   out  [7:0][3:0][3:0]  round key key_sel, [row][col], col c = w[4*key_sel+c]
// BEHAVIOUR
//  Mode table: 128: Nk=4,Nr=10,Nw=44 | 192: Nk=6,Nr=12,Nw=52 | 256: Nk=8,Nr=14,Nw=60.
//  Reset: FSM=IDLE, busy=0, key_rdy=0, key_err=0, round_key=0, word ctr=0, rcon=8'h01.
//   The store is not reset. Reset mid-expansion discards all progress.
//  FSM IDLE -> EXPAND -> DONE.
//  IDLE, encrypt_en=1 at edge: latch mode.
//   Illegal mode (3, or Nk>MAX_NK): pulse key_err, stay IDLE, re-check next edge while encrypt_en=1.
//   Legal mode: write key words 0..Nk-1 to the store, i=Nk, rcon=01, busy=1, go EXPAND.
//  EXPAND: one word per edge. temp=w[i-1].
//   i mod Nk==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon=xtime(rcon).
//     xtime: shift left 1; if bit7 was set, xor 8'h1b.
//   Nk==8 and i mod 8==4: temp=SubWord(temp).
//   w[i]=w[i-Nk]^temp. Track i mod Nk with a wrap counter; no divider.
//   Edge writing w[Nw-1]: busy=0, key_rdy=1, go DONE.
//  Latency: key_rdy high at the (1+Nw-Nk)th rising edge from the start edge (41/47/53).
//  encrypt_en=0 during EXPAND: abort to IDLE, busy=0, key_rdy stays 0.
//  DONE: key_rdy=1 while encrypt_en=1. encrypt_en=0: key_rdy=0, go IDLE.
//   Re-assertion restarts with the current key and mode.
//   cipher_key/key_mode changes in DONE are ignored.
//  round_key is registered: value at edge = store[4*key_sel..+3] of key_sel sampled that edge (1-cycle latency).
//  round_key=0 when key_rdy=0 or key_sel>Nr of latched mode.
//  Every key_sel change in DONE is honoured back-to-back, one new key per cycle.
//  SubWord uses 4 parallel combinational S-box lookups, shared with no other path.
//  key_rdy and busy are never 1 together.
// TESTING
//  T1 AES-128 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c
//     -> key_rdy at edge 41; sel1=a0fafe17 88542cb1 23a33939 2a6c7605;
//     sel10=d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
//  T2 AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b
//     -> key_rdy at edge 47; sel12=e98ba06f 448c773c 8ecc7204 01002202.
//  T3 AES-256 key 603deb10..0914dff4 -> key_rdy at edge 53;
//     sel14=fe4890d1 e6188d0b 046df344 706c631e; sel15 -> round_key=0.
//  T4 key_mode=3 with encrypt_en=1 -> key_err pulses each cycle, busy=0, key_rdy=0.
//     Then mode 0 -> normal T1 result.
//  T5 Drop encrypt_en at edge 20 of EXPAND -> IDLE, key_rdy never rises.
//     Restart as AES-256 -> T3 values; also resetn low mid-EXPAND -> all outputs 0 asynchronously.
//  T6 In DONE, sweep key_sel 0..Nr every cycle -> each round key appears exactly 1 cycle later.
//     Drop encrypt_en -> key_rdy=0, round_key=0 next edge.

Source files
------------

// File: rtl/aes_key_schedule_multi.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock into a round-key store,
// then serves any round key by index with a one-cycle registered read.
module aes_key_schedule_multi #(
  parameter  int unsigned MAX_KEY_WIDTH = 256,
  localparam int unsigned MAX_NK        = MAX_KEY_WIDTH / 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          encrypt_en,
  input  logic [1:0]                    key_mode,
  input  logic [3:0][MAX_NK-1:0][7:0]   cipher_key,
  input  logic [3:0]                    key_sel,
  output logic                          busy,
  output logic                          key_rdy,
  output logic                          key_err,
  output logic [3:0][3:0][7:0]          round_key
);

  localparam int unsigned MAX_NW = 4 * (MAX_NK + 7);
  localparam int unsigned IW     = $clog2(MAX_NW);
  localparam logic [3:0]  MaxNk  = 4'(MAX_NK);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExpand = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox(w[8*b +: 8]);
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [3:0]    nk_q, nk_d;
  logic [IW-1:0] i_q, i_d;
  logic [2:0]    mod_q, mod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          key_rdy_q, key_rdy_d;
  logic          key_err_q, key_err_d;
  logic [3:0][3:0][7:0] round_key_q, round_key_d;

  logic [31:0]   store_q [MAX_NW];

  logic [3:0]    nk_in;
  logic          mode_ok;
  logic          load_en, wr_en;
  logic [31:0]   temp, sub_in, sub_out, w_new;
  logic [IW-1:0] nw_m1;
  logic [3:0]    nr;

  always_comb begin
    unique case (key_mode)
      2'd0:    nk_in = 4'd4;
      2'd1:    nk_in = 4'd6;
      2'd2:    nk_in = 4'd8;
      default: nk_in = 4'd0;
    endcase
  end

  assign mode_ok = (nk_in != 4'd0) && (nk_in <= MaxNk);
  assign nw_m1   = IW'({nk_q, 2'b00}) + IW'(27);
  assign nr      = nk_q + 4'd6;

  // Single SubWord instance: the rotate is muxed in front for the i mod Nk == 0 case.
  always_comb begin
    temp    = store_q[i_q - IW'(1)];
    sub_in  = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    sub_out = sub_word(sub_in);
    if (mod_q == 3'd0) begin
      w_new = store_q[i_q - IW'(nk_q)] ^ sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
      w_new = store_q[i_q - IW'(nk_q)] ^ sub_out;
    end else begin
      w_new = store_q[i_q - IW'(nk_q)] ^ temp;
    end
  end

  always_comb begin
    state_d   = state_q;
    nk_d      = nk_q;
    i_d       = i_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    busy_d    = busy_q;
    key_rdy_d = key_rdy_q;
    key_err_d = 1'b0;
    load_en   = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (encrypt_en) begin
          if (!mode_ok) begin
            key_err_d = 1'b1;
          end else begin
            load_en = 1'b1;
            nk_d    = nk_in;
            i_d     = IW'(nk_in);
            mod_d   = 3'd0;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        if (!encrypt_en) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          wr_en = 1'b1;
          i_d   = i_q + IW'(1);
          mod_d = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (i_q == nw_m1) begin
            busy_d    = 1'b0;
            key_rdy_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        if (!encrypt_en) begin
          key_rdy_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    round_key_d = '0;
    if (state_q == StDone && encrypt_en && key_sel <= nr) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          round_key_d[r][c] = store_q[IW'({key_sel, 2'(c)})][8*(3-r) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      nk_q        <= 4'd4;
      i_q         <= '0;
      mod_q       <= 3'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      key_rdy_q   <= 1'b0;
      key_err_q   <= 1'b0;
      round_key_q <= '0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      i_q         <= i_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      key_rdy_q   <= key_rdy_d;
      key_err_q   <= key_err_d;
      round_key_q <= round_key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int c = 0; c < MAX_NK; c++) begin
        if (4'(c) < nk_in) begin
          store_q[IW'(c)] <= {cipher_key[0][c], cipher_key[1][c],
                              cipher_key[2][c], cipher_key[3][c]};
        end
      end
    end
    if (wr_en) store_q[i_q] <= w_new;
  end

  assign busy      = busy_q;
  assign key_rdy   = key_rdy_q;
  assign key_err   = key_err_q;
  assign round_key = round_key_q;

endmodule
